mop_dispatcher: RTL
===================

# mop_dispatcher

Consumer side of the micro-op cracker. Accepts one packed micro-op bundle per macro-instruction (up to `MAX_MOP_CNT` micro-ops plus a count), buffers up to two bundles, and issues micro-ops to the backend one per cycle over a valid/ready handshake. It marks the first and last micro-op of each macro-instruction so the backend can track instruction boundaries.

## Interface
- `MAX_MOP_CNT`, 6, micro-op slots per bundle
- `MOP_W`, 64, width of one packed `micro_op_t`
- `CNT_W`, 3, width of the count field; must satisfy 2^`CNT_W` > `MAX_MOP_CNT`

- `clk`  in  1  clock; all state on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  bundle present
- `in_ready`  out  1  bundle accepted when `in_valid && in_ready`
- `in_bits`  in  `MAX_MOP_CNT*MOP_W`  packed bundle; slot 0 occupies the most-significant `MOP_W` bits, slot i sits at `[i*MOP_W +: MOP_W]` counted from the MSB
- `in_cnt`  in  `CNT_W`  number of valid slots (0..`MAX_MOP_CNT`)
- `flush`  in  1  discard all buffered and in-flight micro-ops
- `out_valid`  out  1  micro-op present
- `out_ready`  in  1  backend accepts
- `out_mop`  out  `MOP_W`  current micro-op
- `out_first`  out  1  slot 0 of its bundle
- `out_last`  out  1  final slot of its bundle
- `cnt_err`  out  1  sticky: a bundle with `in_cnt > MAX_MOP_CNT` was accepted

## Operation
- Storage: 2-entry bundle FIFO, with a head/tail pointer and a 2-bit occupancy counter. The head entry has a slot index `idx` of width `CNT_W`.
- `in_ready = (occupancy < 2)`. It does not depend on `out_ready`.
- Accepted bundle with `in_cnt == 0`: consumed and dropped. It is not written and produces no output.
- Accepted bundle with `in_cnt > MAX_MOP_CNT`: stored with count clamped to `MAX_MOP_CNT`, and `cnt_err` is set. `cnt_err` clears only on reset.
- Output fields:
  - `out_valid = (occupancy > 0)`
  - `out_mop` = head slot `idx`
  - `out_first = (idx == 0)`
  - `out_last = (idx == head_cnt - 1)`
- On issue (`out_valid && out_ready`):
  - If `out_last`: pop the head and reset `idx` to 0.
  - Otherwise: `idx` increments by 1.
- Simultaneous push and pop are both performed. Occupancy stays unchanged and the pointers wrap modulo 2.
- `flush`:
  - Next cycle: occupancy 0, `idx` 0, `out_valid` 0.
  - `flush` takes priority over a same-cycle accept (that bundle is lost) and over a same-cycle issue (the issue still counts as a completed handshake for the backend).
- Reset (`reset_n == 0` at an edge): same state as flush, and `cnt_err` cleared. Reset mid-bundle abandons the remaining slots.
- Reset values: `out_valid` 0, `out_first` 1, `out_last` 0, `out_mop` 0 (head storage cleared), `cnt_err` 0. `in_ready` is 1 once `reset_n` is high.

## Timing
- Latency, bundle accepted at edge N: slot 0 has `out_valid` during cycle N+1.
- Throughput is one micro-op per cycle under constant `out_ready`. The last slot of bundle A is followed by slot 0 of bundle B on the next cycle with no bubble, when B is already buffered.
- An upstream that keeps a bundle on every cycle sustains full rate whenever the average count is ≥ 1. Full occupancy only deasserts `in_ready`; no data is lost.
- `out_mop`, `out_first`, `out_last` are stable while `out_valid && !out_ready`.

## Configuration
- `MOP_DISPATCH_BYPASS_EN` defined:
  - When occupancy is 0 and a bundle with `in_cnt ≥ 1` is accepted, slot 0 is driven combinationally in the same cycle (`out_valid=1`, `out_first=1`).
  - If it is issued that cycle and `in_cnt == 1`, the bundle is not stored. Otherwise it is stored with `idx` = 1 if issued, else 0.
  - Zero-cycle latency on an empty queue.
- Not defined: outputs depend only on registered state, with 1-cycle minimum latency.

## Test plan
- **Reset then single bundle:** reset, then push `in_cnt=3` with slots A,B,C and `out_ready=1`. Required: outputs A(first),B,C(last) on cycles N+1..N+3, then `out_valid=0`.
- **Backpressure:**
  - Push three bundles of count 4 back-to-back with `out_ready=0`. Required: `in_ready` drops after the 2nd accept and the 3rd waits.
  - Then raise `out_ready`. Required: 8 issues with no gaps, the 3rd is accepted, and the total reaches 12.
- **Zero-count and overflow:**
  - Push `in_cnt=0`. Required: no output and occupancy unchanged.
  - Push `in_cnt=7`. Required: exactly 6 issues and `cnt_err=1`, which stays set until reset.
- **Flush mid-bundle:** push count 5, issue 2, assert `flush` together with a new `in_valid` bundle. Required: next cycle `out_valid=0`, the new bundle is dropped, and a subsequent push starts at slot 0.
- **Stall stability:** while `out_valid=1`, toggle `out_ready` randomly for 50 cycles over bundles of counts 1,2,6. Required: issued sequence and first/last flags match a reference queue exactly.
- **Bypass (macro defined):** push count 1 into an empty queue with `out_ready=1`. Required: issue in the same cycle with first=last=1, occupancy stays 0. Without the macro the same stimulus issues at N+1.

Source files
------------

// File: rtl/mop_dispatcher_if.sv
// Bundle-in / micro-op-out handshake bundle for mop_dispatcher.
// The slave modport is the dispatcher's view. The master modport is the driving side.
interface mop_dispatcher_if #(
   parameter int MAX_MOP_CNT = 6,
   parameter int MOP_W       = 64,
   parameter int CNT_W       = 3
);
   logic                         in_valid;
   logic                         in_ready;
   logic [MAX_MOP_CNT*MOP_W-1:0] in_bits;
   logic [CNT_W-1:0]             in_cnt;
   logic                         flush;
   logic                         out_valid;
   logic                         out_ready;
   logic [MOP_W-1:0]             out_mop;
   logic                         out_first;
   logic                         out_last;
   logic                         cnt_err;

   modport master (
      output in_valid, in_bits, in_cnt, flush, out_ready,
      input  in_ready, out_valid, out_mop, out_first, out_last, cnt_err
   );

   modport slave (
      input  in_valid, in_bits, in_cnt, flush, out_ready,
      output in_ready, out_valid, out_mop, out_first, out_last, cnt_err
   );
endinterface

// File: rtl/mop_dispatcher.sv
// Two-entry micro-op bundle buffer that issues one micro-op per cycle and tags the first and last micro-op.
// Defining MOP_DISPATCH_BYPASS_EN lets slot 0 of a bundle entering an empty queue issue in the same cycle.
module mop_dispatcher #(
   parameter int MAX_MOP_CNT = 6,
   parameter int MOP_W       = 64,
   parameter int CNT_W       = 3
) (
   input logic               clk,
   input logic               reset_n,
   mop_dispatcher_if.slave   bus
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOP_CNT);

   typedef logic [MOP_W-1:0] mop_t;

   mop_t             mem [2][MAX_MOP_CNT];
   logic [CNT_W-1:0] cnt_q [2];
   logic             head_q;
   logic             tail_q;
   logic [1:0]       occ_q;
   logic [CNT_W-1:0] idx_q;
   logic             cnt_err_q;

   logic [CNT_W-1:0] in_cnt_eff;
   logic [CNT_W-1:0] head_cnt;
   logic             accept;
   logic             q_valid;
   logic             q_last;
   mop_t             q_mop;
   logic             byp;
   logic             byp_issue;
   logic             store;
   logic             pop;
   logic             advance;

   logic             out_valid;
   mop_t             out_mop;
   logic             out_first;
   logic             out_last;

   assign bus.in_ready = (occ_q != 2'd2);
   assign accept       = bus.in_valid && bus.in_ready;
   // Oversized counts are clamped so the head never walks past the last real slot.
   assign in_cnt_eff   = (bus.in_cnt > MAX_CNT) ? MAX_CNT : bus.in_cnt;

   assign head_cnt = cnt_q[head_q];
   assign q_valid  = (occ_q != 2'd0);
   assign q_last   = (idx_q == head_cnt - CNT_W'(1));
   assign q_mop    = (idx_q < MAX_CNT) ? mem[head_q][idx_q] : '0;

`ifdef MOP_DISPATCH_BYPASS_EN
   assign byp = !q_valid && accept && (bus.in_cnt != '0);
`else
   assign byp = 1'b0;
`endif

   // NOTE: every output gets a default before the override, so no latch can be inferred.
   always_comb begin
      out_valid = q_valid;
      out_mop   = q_mop;
      out_first = (idx_q == '0);
      out_last  = q_last;
`ifdef MOP_DISPATCH_BYPASS_EN
      if (byp) begin
         out_valid = 1'b1;
         out_mop   = bus.in_bits[MAX_MOP_CNT*MOP_W-1 -: MOP_W];
         out_first = 1'b1;
         out_last  = (in_cnt_eff == CNT_W'(1));
      end
`endif
   end

   assign bus.out_valid = out_valid;
   assign bus.out_mop   = out_mop;
   assign bus.out_first = out_first;
   assign bus.out_last  = out_last;
   assign bus.cnt_err   = cnt_err_q;

   // A bypassed single-slot bundle that issues immediately never touches storage.
   assign byp_issue = byp && bus.out_ready;
   assign store     = accept && (bus.in_cnt != '0) && !(byp_issue && (in_cnt_eff == CNT_W'(1)));
   assign pop       = q_valid && bus.out_ready && q_last;
   assign advance   = q_valid && bus.out_ready && !q_last;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_q    <= 1'b0;
         tail_q    <= 1'b0;
         occ_q     <= 2'd0;
         idx_q     <= '0;
         cnt_err_q <= 1'b0;
         // NOTE: the bundle storage is reset too, so out_mop reads 0 after reset instead of stale data.
         for (int e = 0; e < 2; e++) begin
            cnt_q[e] <= '0;
            for (int s = 0; s < MAX_MOP_CNT; s++) mem[e][s] <= '0;
         end
      end else if (bus.flush) begin
         head_q <= 1'b0;
         tail_q <= 1'b0;
         occ_q  <= 2'd0;
         idx_q  <= '0;
      end else begin
         if (store) begin
            for (int s = 0; s < MAX_MOP_CNT; s++)
               mem[tail_q][s] <= bus.in_bits[(MAX_MOP_CNT-1-s)*MOP_W +: MOP_W];
            cnt_q[tail_q] <= in_cnt_eff;
            tail_q        <= ~tail_q;
         end
         if (pop) head_q <= ~head_q;
         occ_q <= occ_q + {1'b0, store} - {1'b0, pop};

         if (byp)          idx_q <= CNT_W'(byp_issue && store);
         else if (pop)     idx_q <= '0;
         else if (advance) idx_q <= idx_q + CNT_W'(1);

         if (accept && (bus.in_cnt > MAX_CNT)) cnt_err_q <= 1'b1;
      end
   end
endmodule
